// File: rtl/stp_wrapper.sv
// stp_wrapper: serial-to-parallel word shift register with frame counting.
//
// Words presented on serial_in are shifted in on every clock where
// it_cnt_strobe is high. New words enter at the top index and age toward
// index 0. After NUM_WORDS strobes, the first word of the frame therefore sits
// at data_par[0].
//
// word_cnt counts accepted words modulo NUM_WORDS. frame_done pulses for one
// cycle after the strobe that completes a frame. Shifting continues across
// frame boundaries and is never blocked.
//
// Ports
//   clk           : clock, rising-edge active
//   n_rst         : synchronous reset, active-high (despite the name)
//   it_cnt_strobe : shift enable, one word accepted per high cycle
//   serial_in     : incoming word, WORD_WIDTH bits
//   data_par      : registered parallel contents, [NUM_WORDS-1:0][WORD_WIDTH-1:0]
//   word_cnt      : words accepted since reset or since the last full frame
//   frame_done    : registered one-cycle frame completion pulse
module stp_wrapper #(
  parameter int NUM_WORDS  = 48,
  parameter int WORD_WIDTH = 16,
  localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic                                   it_cnt_strobe,
  input  logic [WORD_WIDTH-1:0]                  serial_in,
  output logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]   data_par,
  output logic [CNT_W-1:0]                       word_cnt,
  output logic                                   frame_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  // Data and control share one register stage so all outputs stay aligned.
  // The reset clears the data words as well, so a fresh frame always starts
  // from all-zero contents.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      data_par   <= '0;
      word_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (it_cnt_strobe) begin
        // Concatenation drops data_par[0] and moves every word down by one.
        data_par <= {serial_in, data_par[NUM_WORDS-1:1]};
        if (word_cnt == LAST_CNT) begin
          word_cnt   <= '0;
          frame_done <= 1'b1;
        end else begin
          word_cnt <= word_cnt + ONE_CNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_stp_wrapper.sv
// tb_stp_wrapper: randomized and directed bench for stp_wrapper.
// A word-array reference model tracks the expected contents, count and frame
// pulse. The bench compares the DUT against that model after every clock edge.
module tb_stp_wrapper;

  localparam int NW = 48;
  localparam int WW = 16;
  localparam int CW = $clog2(NW + 1);
  localparam int VW = NW * WW;

  logic                       clk = 1'b0;
  logic                       n_rst = 1'b1;
  logic                       it_cnt_strobe = 1'b0;
  logic [WW-1:0]              serial_in = '0;
  logic [NW-1:0][WW-1:0]      data_par;
  logic [CW-1:0]              word_cnt;
  logic                       frame_done;

  stp_wrapper #(.NUM_WORDS(NW), .WORD_WIDTH(WW)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .it_cnt_strobe (it_cnt_strobe),
    .serial_in     (serial_in),
    .data_par      (data_par),
    .word_cnt      (word_cnt),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [WW-1:0] m_word[NW];
  int            m_cnt;
  bit            m_fd;
  int            fd_seen;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NW; i++) v[i*WW +: WW] = m_word[i];
    return v;
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit s, input logic [WW-1:0] d);
    n_rst         = r;
    it_cnt_strobe = s;
    serial_in     = d;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NW; i++) m_word[i] = '0;
      m_cnt = 0;
      m_fd  = 0;
    end else begin
      m_fd = 0;
      if (s) begin
        // oldest word falls out of index 0, newest enters at the top
        for (int i = 0; i < NW - 1; i++) m_word[i] = m_word[i+1];
        m_word[NW-1] = d;
        m_cnt = (m_cnt + 1) % NW;
        if (m_cnt == 0) m_fd = 1;
      end
    end
    #1;
    check("data_par", data_par, model_vec());
    check("word_cnt", VW'(word_cnt), VW'(m_cnt));
    check("frame_done", VW'(frame_done), VW'(m_fd));
    if (frame_done) fd_seen++;
  endtask

  initial begin
    logic [VW-1:0] exp_vec;
    logic [VW-1:0] snap;
    logic [CW-1:0] cnt_snap;

    for (int i = 0; i < NW; i++) m_word[i] = '0;
    m_cnt = 0;
    m_fd = 0;
    fd_seen = 0;

    // Reset, then one idle cycle.
    step(1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b0, 16'h5678);
    check("reset_data_zero", data_par, '0);

    // Full frame of words 0..47, then idle.
    fd_seen = 0;
    for (int i = 0; i < NW; i++) step(1'b0, 1'b1, WW'(i));
    check("frame_pulse_at_48", VW'(frame_done), VW'(1));
    step(1'b0, 1'b0, 16'hAAAA);
    exp_vec = '0;
    for (int i = 0; i < NW; i++) exp_vec[i*WW +: WW] = WW'(i);
    check("frame_ordered", data_par, exp_vec);
    check("frame_done_cleared", VW'(frame_done), VW'(0));
    check("frame_pulse_count", VW'(fd_seen), VW'(1));
    check("frame_cnt_wrap", VW'(word_cnt), VW'(0));

    // One more word crosses into the next frame.
    step(1'b0, 1'b1, 16'hBEEF);
    check("beef_w0", VW'(data_par[0]), VW'(1));
    check("beef_w46", VW'(data_par[46]), VW'(47));
    check("beef_w47", VW'(data_par[47]), VW'(16'hBEEF));
    check("beef_cnt", VW'(word_cnt), VW'(1));

    // Ten words separated by idle cycles, starting from reset.
    step(1'b1, 1'b0, '0);
    fd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, WW'($urandom));
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) step(1'b0, 1'b0, WW'($urandom));
    end
    check("gap_cnt10", VW'(word_cnt), VW'(10));
    check("gap_low_zero", VW'(data_par[37:0]), '0);
    check("gap_no_pulse", VW'(fd_seen), VW'(0));

    // Twenty words, then reset together with a strobed FFFF.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, WW'($urandom));
    step(1'b1, 1'b1, 16'hFFFF);
    check("rst_prio_data", data_par, '0);
    check("rst_prio_cnt", VW'(word_cnt), VW'(0));
    fd_seen = 0;
    for (int i = 0; i < NW; i++) step(1'b0, 1'b1, WW'($urandom));
    check("post_rst_one_pulse", VW'(fd_seen), VW'(1));

    // Partial frame, then twenty idle cycles with a toggling input.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, WW'($urandom));
    snap = data_par;
    cnt_snap = word_cnt;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, WW'($urandom));
    check("idle_data_hold", data_par, snap);
    check("idle_cnt_hold", VW'(word_cnt), VW'(cnt_snap));
    check("idle_no_pulse", VW'(frame_done), VW'(0));

    // Random mix of strobes, idles and occasional resets.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, WW'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
